mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multi-cycle control sequencer for the RV32I core. Consumes the decoder's opcode/func3 fields.
//  Drives PC/IR/regfile write enables, datapath mux selects and a single shared memory port.
//  That port is used for both instruction fetch and load/store. Sits between the decoder and the datapath.
// PARAMETERS
//  AW  32  address width (passed to datapath mux widths; no internal use beyond width checks)
//  DW  32  data width
// PORTS
//  clk          in   1   core clock
//  rst          in   1   synchronous, active-high reset
//  opcode       in   7   instr[6:0] from decoder (valid from DECODE onward)
//  func3        in   3   instr[14:12] from decoder
//  br_taken     in   1   branch-condition result from ALU compare (valid in EXEC)
//  mem_ack      in   1   memory response; one-cycle pulse completing the outstanding request
//  mem_req      out  1   memory request, held until mem_ack
//  mem_we       out  1   store qualifier for mem_req
//  mem_addr_sel out  1   0 = PC (fetch), 1 = ALU result (data)
//  ir_we        out  1   latch fetched word into IR
//  pc_we        out  1   update PC
//  pc_sel       out  2   next-PC source (pc_sel_e)
//  rf_we        out  1   regfile write enable
//  wb_sel       out  2   writeback source (wb_sel_e)
//  alu_a_sel    out  1   0 = rs1, 1 = PC
//  alu_b_sel    out  1   0 = rs2, 1 = immediate
//  trap         out  1   illegal opcode seen; sticky until rst
//  state_o      out  3   current state (debug)
// BEHAVIOUR
//  - All outputs are Moore/decoded from the registered state and the opcode class. No output is combinational from mem_ack, except ir_we/pc_we/rf_we gating noted below.
//  - Reset: state=FETCH, trap=0. Every enable and mem_req is 0 in the reset cycle. mem_req rises the first cycle after rst deasserts.
//  - FETCH: mem_req=1, mem_we=0, addr_sel=0. Stay while !mem_ack. On mem_ack: ir_we=1 (same cycle), go to DECODE.
//  - DECODE: 1 cycle. Classify opcode: OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE go to EXEC; any other opcode goes to TRAP.
//  - EXEC: 1 cycle. Set alu_a_sel/alu_b_sel per class.
//    - BRANCH: pc_we=1, pc_sel = br_taken ? PC_TARGET : PC_PLUS4, then FETCH.
//    - LOAD/STORE: go to MEM.
//    - All other classes: go to WB.
//  - MEM: mem_req=1, addr_sel=1, mem_we=(STORE). Stay while !mem_ack.
//    - On ack with LOAD: go to WB.
//    - On ack with STORE: pc_we=1 with PC_PLUS4, then FETCH.
//  - WB: rf_we=1, pc_we=1, then FETCH. wb_sel/pc_sel by class:
//    - LOAD: MEM / PLUS4
//    - LUI: IMM / PLUS4
//    - JAL: PC4 / TARGET
//    - JALR: PC4 / ALU (datapath clears bit0)
//    - others: ALU / PLUS4
//  - TRAP: all enables and mem_req are 0; trap=1. Terminal until rst.
//  - Latency with a zero-wait memory (ack the cycle after req rises):
//    - ALU/jump instruction: 4 cycles
//    - load: 5 cycles
//    - store: 4 cycles
//    - branch: 3 cycles
//  - Each wait cycle on mem_ack adds one cycle.
//  - mem_ack while mem_req=0: ignored, no state change.
//  - rst mid-request: request dropped next edge. The memory must tolerate an abandoned req.
//  - func3 is used only to flag an illegal LOAD/STORE width (func3 of 3, 6, 7 on load; >2 on store), which goes to TRAP.
// CONFIGURATION
//  MC_CTRL_INSTRET_EN defined:
//    - adds output instret (64 bit), reset 0.
//    - Increments by 1 on every cycle where pc_we=1, i.e. each retired instruction; wraps modulo 2^64.
//  MC_CTRL_INSTRET_EN undefined: no port and no counter logic.
// STRUCTURE
//  mc_ctrl_pkg contains:
//    - state_e {FETCH, DECODE, EXEC, MEM, WB, TRAP}
//    - opclass_e
//    - pc_sel_e {PC_PLUS4, PC_TARGET, PC_ALU}
//    - wb_sel_e {WB_ALU, WB_MEM, WB_PC4, WB_IMM}
//    - RV32I opcode localparams
//  Sub-module mc_ctrl_opclass: combinational opcode/func3 -> opclass_e + illegal flag.
//  The FSM and output decode live in this module.
// TESTING
//  1. Reset, then ADD (0110011) with zero-wait ack -> FETCH, DECODE, EXEC, WB. rf_we=1 and pc_we=1 (PLUS4) only in cycle 4.
//  2. LW (0000011, func3=2) with ack delayed 3 cycles in MEM -> mem_req held 4 cycles with addr_sel=1, then WB with wb_sel=WB_MEM.
//  3. BEQ (1100011) with br_taken=1, then br_taken=0 -> pc_sel = PC_TARGET, then PC_PLUS4. No rf_we in either.
//  4. Opcode 0000000 -> TRAP after DECODE; trap=1; mem_req stays 0 for 20 cycles; rst returns to FETCH with trap=0.
//  5. rst asserted during FETCH wait (ack never seen) -> mem_req=0 next cycle, state=FETCH. A stray mem_ack in the reset cycle is ignored.
//  6. With MC_CTRL_INSTRET_EN: 3 ALU instructions, 1 store and 1 taken branch -> instret=5.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and RV32I opcode constants for the multi-cycle control sequencer.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        OC_OP,
        OC_OPIMM,
        OC_LUI,
        OC_AUIPC,
        OC_JAL,
        OC_JALR,
        OC_BRANCH,
        OC_LOAD,
        OC_STORE,
        OC_ILLEGAL
    } opclass_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_TARGET = 2'd1,
        PC_ALU    = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

endpackage

// File: rtl/mc_ctrl_opclass.sv
// Combinational opcode/func3 classifier; unsupported opcodes and illegal
// load/store widths both map to OC_ILLEGAL.
module mc_ctrl_opclass
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] func3_i,
    output opclass_e   opclass_o,
    output logic       illegal_o
);

    always_comb begin
        opclass_o = OC_ILLEGAL;
        case (opcode_i)
            OPC_OP:     opclass_o = OC_OP;
            OPC_OPIMM:  opclass_o = OC_OPIMM;
            OPC_LUI:    opclass_o = OC_LUI;
            OPC_AUIPC:  opclass_o = OC_AUIPC;
            OPC_JAL:    opclass_o = OC_JAL;
            OPC_JALR:   opclass_o = OC_JALR;
            OPC_BRANCH: opclass_o = OC_BRANCH;
            // LB/LH/LW/LBU/LHU only; SB/SH/SW only
            OPC_LOAD:   opclass_o = (func3_i == 3'd3 || func3_i == 3'd6 || func3_i == 3'd7)
                                    ? OC_ILLEGAL : OC_LOAD;
            OPC_STORE:  opclass_o = (func3_i > 3'd2) ? OC_ILLEGAL : OC_STORE;
            default:    opclass_o = OC_ILLEGAL;
        endcase
    end

    assign illegal_o = (opclass_o == OC_ILLEGAL);

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer sharing one memory port between fetch and load/store.
// Optional retired-instruction counter enabled by defining MC_CTRL_INSTRET_EN.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic        br_taken,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        alu_a_sel,
    output logic        alu_b_sel,
    output logic        trap,
    output logic [2:0]  state_o
`ifdef MC_CTRL_INSTRET_EN
    ,
    output logic [63:0] instret
`endif
);

    if (AW < 1 || DW < 1) begin : g_param_chk
        $error("mc_ctrl_fsm: AW and DW must be positive");
    end

    state_e   state_q, state_d;
    opclass_e opclass;
    logic     illegal;
    pc_sel_e  pc_sel_d;
    wb_sel_e  wb_sel_d;

    mc_ctrl_opclass u_opclass (
        .opcode_i  (opcode),
        .func3_i   (func3),
        .opclass_o (opclass),
        .illegal_o (illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel_d     = PC_PLUS4;
        rf_we        = 1'b0;
        wb_sel_d     = WB_ALU;
        alu_a_sel    = 1'b0;
        alu_b_sel    = 1'b0;

        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_we   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = illegal ? TRAP : EXEC;
            end
            EXEC: begin
                alu_a_sel = (opclass == OC_AUIPC) || (opclass == OC_JAL);
                alu_b_sel = !((opclass == OC_OP) || (opclass == OC_BRANCH));
                case (opclass)
                    OC_BRANCH: begin
                        pc_we    = 1'b1;
                        pc_sel_d = br_taken ? PC_TARGET : PC_PLUS4;
                        state_d  = FETCH;
                    end
                    OC_LOAD, OC_STORE: state_d = MEM;
                    default:           state_d = WB;
                endcase
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opclass == OC_STORE);
                if (mem_ack) begin
                    if (opclass == OC_STORE) begin
                        pc_we   = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = FETCH;
                case (opclass)
                    OC_LOAD: wb_sel_d = WB_MEM;
                    OC_LUI:  wb_sel_d = WB_IMM;
                    OC_JAL: begin
                        wb_sel_d = WB_PC4;
                        pc_sel_d = PC_TARGET;
                    end
                    OC_JALR: begin
                        wb_sel_d = WB_PC4;
                        pc_sel_d = PC_ALU;
                    end
                    default: wb_sel_d = WB_ALU;
                endcase
            end
            TRAP:    state_d = TRAP;
            default: state_d = FETCH;
        endcase

        // Nothing may reach the datapath or memory while reset is held.
        if (rst) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_we        = 1'b0;
            pc_we        = 1'b0;
            rf_we        = 1'b0;
            pc_sel_d     = PC_PLUS4;
            wb_sel_d     = WB_ALU;
            alu_a_sel    = 1'b0;
            alu_b_sel    = 1'b0;
        end
    end

    assign pc_sel  = pc_sel_d;
    assign wb_sel  = wb_sel_d;
    assign trap    = (state_q == TRAP);
    assign state_o = state_q;

`ifdef MC_CTRL_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (pc_we) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed vector table, hand-written corner
// sequences and randomized instruction streams against a transaction-level model.
module tb_mc_ctrl_fsm;

    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
                           S_MEM = 3'd3, S_WB = 3'd4, S_TRAP = 3'd5;
    localparam logic [1:0] P_PLUS4 = 2'd0, P_TARGET = 2'd1, P_ALU = 2'd2;
    localparam logic [1:0] W_ALU = 2'd0, W_MEM = 2'd1, W_PC4 = 2'd2, W_IMM = 2'd3;
    localparam logic [6:0] OP_OP = 7'b0110011, OP_OPIMM = 7'b0010011, OP_LUI = 7'b0110111,
                           OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111,
                           OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011;

    typedef struct packed {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       br;
        logic       ack;
    } in_t;

    typedef struct packed {
        logic       req;
        logic       we;
        logic       asel;
        logic       irwe;
        logic       pcwe;
        logic [1:0] pcsel;
        logic       rfwe;
        logic [1:0] wbsel;
        logic       alua;
        logic       alub;
        logic       trap;
        logic [2:0] st;
    } out_t;

    typedef struct {
        in_t  i;
        out_t e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        br_taken;
    logic        mem_ack;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, rf_we;
    logic [1:0]  pc_sel, wb_sel;
    logic        alu_a_sel, alu_b_sel, trap;
    logic [2:0]  state_o;
`ifdef MC_CTRL_INSTRET_EN
    logic [63:0] instret;
    longint unsigned exp_instret = 0;
`endif

    int checks = 0;
    int errors = 0;
    vec_t q[$];
    vec_t tbl[11];

    mc_ctrl_fsm #(.AW(32), .DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .func3        (func3),
        .br_taken     (br_taken),
        .mem_ack      (mem_ack),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .trap         (trap),
        .state_o      (state_o)
`ifdef MC_CTRL_INSTRET_EN
        ,
        .instret      (instret)
`endif
    );

    always #5 clk = ~clk;

    function automatic out_t sample();
        out_t a;
        a = '{req: mem_req, we: mem_we, asel: mem_addr_sel, irwe: ir_we, pcwe: pc_we,
              pcsel: pc_sel, rfwe: rf_we, wbsel: wb_sel, alua: alu_a_sel, alub: alu_b_sel,
              trap: trap, st: state_o};
        return a;
    endfunction

    // Drive one cycle of inputs, compare outputs at the falling edge. In reset
    // cycles only the request/enable outputs are required to be quiet.
    task automatic run_cycle(input in_t i, input out_t e, input string nm);
        out_t a;
        rst = i.rst; opcode = i.op; func3 = i.f3; br_taken = i.br; mem_ack = i.ack;
        @(negedge clk);
        a = sample();
        if (i.rst) begin
            a.pcsel = '0; a.wbsel = '0; a.alua = 1'b0; a.alub = 1'b0; a.trap = 1'b0; a.st = '0;
        end
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s t=%0t got=%05h want=%05h", nm, $time, a, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic push(input in_t i, input out_t e);
        vec_t v;
        v.i = i; v.e = e;
        q.push_back(v);
    endtask

    task automatic push_rst();
        in_t i;
        i = '{rst: 1'b1, op: 7'($urandom), f3: 3'($urandom), br: 1'($urandom), ack: 1'($urandom)};
        push(i, '0);
    endtask

    task automatic play(input string nm);
        vec_t v;
        while (q.size() > 0) begin
            v = q.pop_front();
            run_cycle(v.i, v.e, nm);
        end
    endtask

    function automatic in_t live(input logic [6:0] op, input logic [2:0] f3);
        in_t i;
        i = '{rst: 1'b0, op: op, f3: f3, br: 1'($urandom), ack: 1'($urandom)};
        return i;
    endfunction

    // Reference model: expands one instruction into its expected cycle trace from the
    // instruction's class, the branch outcome and the memory wait counts.
    task automatic gen_instr(input logic [6:0] op, input logic [2:0] f3, input logic br,
                             input int fw, input int mw);
        bit   is_ld, is_st, is_br, legal, a_pc, b_imm;
        in_t  i;
        out_t e;
        is_ld = (op == OP_LOAD);
        is_st = (op == OP_STORE);
        is_br = (op == OP_BRANCH);
        legal = (op inside {OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
                            OP_BRANCH, OP_LOAD, OP_STORE});
        if (is_ld && (f3 inside {3'd3, 3'd6, 3'd7})) legal = 1'b0;
        if (is_st && f3 > 3'd2) legal = 1'b0;
        a_pc  = (op == OP_AUIPC) || (op == OP_JAL);
        b_imm = !((op == OP_OP) || is_br);

        for (int k = 0; k <= fw; k++) begin
            i = '{rst: 1'b0, op: 7'($urandom), f3: 3'($urandom), br: 1'($urandom), ack: (k == fw)};
            e = '{req: 1'b1, irwe: (k == fw), st: S_FETCH, default: '0};
            push(i, e);
        end
        push(live(op, f3), '{st: S_DECODE, default: '0});
        if (!legal) begin
            for (int k = 0; k < 3; k++) push(live(op, f3), '{trap: 1'b1, st: S_TRAP, default: '0});
            push_rst();
`ifdef MC_CTRL_INSTRET_EN
            exp_instret = 0;
`endif
            return;
        end

        i = live(op, f3);
        e = '{alua: a_pc, alub: b_imm, st: S_EXEC, default: '0};
        if (is_br) begin
            i.br    = br;
            e.pcwe  = 1'b1;
            e.pcsel = br ? P_TARGET : P_PLUS4;
        end
        push(i, e);

        if (is_ld || is_st) begin
            for (int k = 0; k <= mw; k++) begin
                i = live(op, f3);
                i.ack = (k == mw);
                e = '{req: 1'b1, we: is_st, asel: 1'b1, st: S_MEM, default: '0};
                if (k == mw && is_st) e.pcwe = 1'b1;
                push(i, e);
            end
        end

        if (!is_br && !is_st) begin
            e = '{rfwe: 1'b1, pcwe: 1'b1, st: S_WB, default: '0};
            if (is_ld) e.wbsel = W_MEM;
            else if (op == OP_LUI) e.wbsel = W_IMM;
            else if (op == OP_JAL) begin e.wbsel = W_PC4; e.pcsel = P_TARGET; end
            else if (op == OP_JALR) begin e.wbsel = W_PC4; e.pcsel = P_ALU; end
            push(live(op, f3), e);
        end
`ifdef MC_CTRL_INSTRET_EN
        exp_instret++;
`endif
    endtask

    initial begin
        logic [6:0] ops[9];
        logic [6:0] op;
        logic [2:0] f3;
        int         r;
        ops = '{OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE};

        // ADD zero-wait, BEQ taken, BEQ not taken, then an idle fetch cycle
        tbl[0]  = '{'{rst: 0, op: OP_OP, f3: 0, br: 0, ack: 1}, '{req: 1, irwe: 1, st: S_FETCH, default: '0}};
        tbl[1]  = '{'{rst: 0, op: OP_OP, f3: 0, br: 0, ack: 1}, '{st: S_DECODE, default: '0}};
        tbl[2]  = '{'{rst: 0, op: OP_OP, f3: 0, br: 1, ack: 0}, '{st: S_EXEC, default: '0}};
        tbl[3]  = '{'{rst: 0, op: OP_OP, f3: 0, br: 0, ack: 1}, '{rfwe: 1, pcwe: 1, pcsel: P_PLUS4, wbsel: W_ALU, st: S_WB, default: '0}};
        tbl[4]  = '{'{rst: 0, op: OP_BRANCH, f3: 0, br: 0, ack: 1}, '{req: 1, irwe: 1, st: S_FETCH, default: '0}};
        tbl[5]  = '{'{rst: 0, op: OP_BRANCH, f3: 0, br: 0, ack: 0}, '{st: S_DECODE, default: '0}};
        tbl[6]  = '{'{rst: 0, op: OP_BRANCH, f3: 0, br: 1, ack: 0}, '{pcwe: 1, pcsel: P_TARGET, st: S_EXEC, default: '0}};
        tbl[7]  = '{'{rst: 0, op: OP_BRANCH, f3: 0, br: 1, ack: 1}, '{req: 1, irwe: 1, st: S_FETCH, default: '0}};
        tbl[8]  = '{'{rst: 0, op: OP_BRANCH, f3: 0, br: 1, ack: 0}, '{st: S_DECODE, default: '0}};
        tbl[9]  = '{'{rst: 0, op: OP_BRANCH, f3: 0, br: 0, ack: 0}, '{pcwe: 1, pcsel: P_PLUS4, st: S_EXEC, default: '0}};
        tbl[10] = '{'{rst: 0, op: OP_OP, f3: 0, br: 0, ack: 0}, '{req: 1, st: S_FETCH, default: '0}};

        rst = 1'b1; opcode = '0; func3 = '0; br_taken = 1'b0; mem_ack = 1'b0;
        @(posedge clk); #1;
        push_rst(); push_rst(); play("reset_cycle");
        chk("reset_state", {61'd0, state_o}, {61'd0, S_FETCH});
        chk("reset_trap", {63'd0, trap}, 64'd0);
        chk("reset_mem_req", {63'd0, mem_req}, 64'd0);

        for (int k = 0; k < 11; k++) run_cycle(tbl[k].i, tbl[k].e, $sformatf("table[%0d]", k));

        // LW with three wait cycles in MEM
        gen_instr(OP_LOAD, 3'd2, 1'b0, 1, 3);
        play("lw_wait");

        push_rst();
`ifdef MC_CTRL_INSTRET_EN
        exp_instret = 0;
`endif
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 11);
            if (r < 9) begin
                op = ops[r];
                f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2));
            end else if (r == 9) begin
                op = 7'($urandom); f3 = 3'($urandom);
            end else if (r == 10) begin
                op = OP_LOAD; f3 = ($urandom_range(0, 1) == 0) ? 3'd3 : 3'd6;
            end else begin
                op = OP_STORE; f3 = 3'($urandom_range(3, 7));
            end
            gen_instr(op, f3, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        play("random");
`ifdef MC_CTRL_INSTRET_EN
        chk("instret_random", instret, exp_instret);
`endif

        // Illegal opcode: sticky trap with no memory traffic, cleared only by reset
        run_cycle('{rst: 0, op: 7'd0, f3: 0, br: 0, ack: 1}, '{req: 1, irwe: 1, st: S_FETCH, default: '0}, "trap_fetch");
        run_cycle('{rst: 0, op: 7'd0, f3: 0, br: 0, ack: 0}, '{st: S_DECODE, default: '0}, "trap_decode");
        for (int k = 0; k < 20; k++)
            run_cycle('{rst: 0, op: 7'($urandom), f3: 3'($urandom), br: 1'($urandom), ack: 1'($urandom)},
                      '{trap: 1, st: S_TRAP, default: '0}, "trap_hold");
        run_cycle('{rst: 1, op: 7'd0, f3: 0, br: 0, ack: 0}, '0, "trap_rst");
        run_cycle('{rst: 0, op: 7'd0, f3: 0, br: 0, ack: 0}, '{req: 1, st: S_FETCH, default: '0}, "trap_recover");

        // Reset while a fetch is outstanding, with a stray ack in the reset cycle
        for (int k = 0; k < 3; k++)
            run_cycle('{rst: 0, op: OP_OP, f3: 0, br: 0, ack: 0}, '{req: 1, st: S_FETCH, default: '0}, "fetch_wait");
        run_cycle('{rst: 1, op: OP_OP, f3: 0, br: 0, ack: 1}, '0, "rst_mid_fetch");
        run_cycle('{rst: 0, op: OP_OP, f3: 0, br: 0, ack: 0}, '{req: 1, st: S_FETCH, default: '0}, "after_rst_fetch");
        gen_instr(OP_OP, 3'd0, 1'b0, 0, 0);
        play("after_rst_add");

`ifdef MC_CTRL_INSTRET_EN
        push_rst();
        gen_instr(OP_OP, 3'd0, 1'b0, 0, 0);
        gen_instr(OP_OPIMM, 3'd0, 1'b0, 1, 0);
        gen_instr(OP_LUI, 3'd0, 1'b0, 0, 0);
        gen_instr(OP_STORE, 3'd2, 1'b0, 0, 1);
        gen_instr(OP_BRANCH, 3'd0, 1'b1, 0, 0);
        play("instret_mix");
        chk("instret_five", instret, 64'd5);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
